alu_issue_stage: RTL and testbench

- ID/EX pipeline stage that drives the ALU and consumes its result.
- Decodes RV32I OP, OP-IMM and BRANCH instructions into the 4-bit ALU operation code.
- Registers SrcA, SrcB and Operation, then forwards the combinational ALUResult to writeback or to branch resolution.
- Uses a single-entry valid/ready pipeline register with stall, redirect-flush and a retired-instruction counter.

---
 rtl/alu_issue_stage.sv | 110 +++++++++++
 tb/tb_alu_issue_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX stage decoding RV32I OP/OP-IMM/BRANCH into ALU operands and codes.
module alu_issue_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    output logic                     id_ready,
    input  logic [6:0]               id_opcode,
    input  logic [2:0]               id_funct3,
    input  logic                     id_funct7b5,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [DATA_WIDTH-1:0]    id_pc,
    input  logic [4:0]               id_rd,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    input  logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     ex_valid,
    input  logic                     ex_ready,
    output logic [DATA_WIDTH-1:0]    ex_result,
    output logic [4:0]               ex_rd,
    output logic                     ex_we,
    output logic                     ex_illegal,
    output logic                     redirect,
    output logic [DATA_WIDTH-1:0]    redirect_pc,
    output logic [CNT_WIDTH-1:0]     retired_cnt
);
    localparam logic [6:0] OPC_OP = 7'b0110011, OPC_IMM = 7'b0010011, OPC_BR = 7'b1100011;
    localparam logic [OPCODE_LENGTH-1:0] C_AND = OPCODE_LENGTH'(0), C_OR = OPCODE_LENGTH'(1),
        C_ADD = OPCODE_LENGTH'(2), C_SUB = OPCODE_LENGTH'(3), C_XOR = OPCODE_LENGTH'(4),
        C_SRL = OPCODE_LENGTH'(5), C_SRA = OPCODE_LENGTH'(6), C_SLL = OPCODE_LENGTH'(7),
        C_LT = OPCODE_LENGTH'(8), C_EQ = OPCODE_LENGTH'(9), C_NE = OPCODE_LENGTH'(10),
        C_GE = OPCODE_LENGTH'(11);
    logic [OPCODE_LENGTH-1:0] dec_op;
    logic dec_alu, dec_br, dec_ill, dec_imm, accept, fire, is_alu, is_br;
    always_comb begin
        dec_op  = C_AND;
        dec_alu = 1'b0;
        dec_br  = 1'b0;
        dec_ill = 1'b0;
        dec_imm = id_opcode == OPC_IMM;
        case (id_opcode)
            OPC_OP, OPC_IMM: begin
                dec_alu = 1'b1;
                case (id_funct3)
                    3'b000: dec_op = (id_funct7b5 && !dec_imm) ? C_SUB : C_ADD;
                    3'b001: dec_op = C_SLL;
                    3'b010: dec_op = C_LT;
                    3'b011: dec_ill = 1'b1;
                    3'b100: dec_op = C_XOR;
                    3'b101: dec_op = id_funct7b5 ? C_SRA : C_SRL;
                    3'b110: dec_op = C_OR;
                    3'b111: dec_op = C_AND;
                endcase
            end
            OPC_BR: begin
                dec_br = 1'b1;
                case (id_funct3)
                    3'b000:  dec_op = C_EQ;
                    3'b001:  dec_op = C_NE;
                    3'b100:  dec_op = C_LT;
                    3'b101:  dec_op = C_GE;
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end
    assign fire      = ex_valid & ex_ready;
    assign redirect  = fire & is_br & ALUResult[0];
    assign id_ready  = (~ex_valid | ex_ready) & ~redirect;
    assign accept    = id_valid & id_ready;
    assign ex_we     = ex_valid & is_alu;
    assign ex_result = is_alu ? ALUResult : '0;
    // Illegal instructions load zeroed operands and no class flag, so they retire inertly.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            SrcA        <= '0;
            SrcB        <= '0;
            Operation   <= '0;
            ex_rd       <= '0;
            redirect_pc <= '0;
            is_alu      <= 1'b0;
            is_br       <= 1'b0;
            ex_illegal  <= 1'b0;
            retired_cnt <= '0;
        end else begin
            if (accept) begin
                ex_valid    <= 1'b1;
                SrcA        <= dec_ill ? '0 : id_rs1_data;
                SrcB        <= dec_ill ? '0 : (dec_imm ? id_imm : id_rs2_data);
                Operation   <= dec_ill ? C_AND : dec_op;
                ex_rd       <= id_rd;
                redirect_pc <= id_pc + id_imm;
                is_alu      <= dec_alu & ~dec_ill;
                is_br       <= dec_br & ~dec_ill;
                ex_illegal  <= dec_ill;
            end else if (fire) begin
                ex_valid <= 1'b0;
            end
            if (fire) retired_cnt <= retired_cnt + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: random and directed checks of alu_issue_stage against an instruction-level model.
module tb_alu_issue_stage;
    localparam logic [6:0] OPC_OP = 7'b0110011, OPC_IMM = 7'b0010011, OPC_BR = 7'b1100011;
    logic clk = 1'b0, reset = 1'b1, id_valid = 1'b0, id_ready, id_funct7b5 = 1'b0;
    logic [6:0] id_opcode = '0;
    logic [2:0] id_funct3 = '0;
    logic [31:0] id_rs1_data = '0, id_rs2_data = '0, id_imm = '0, id_pc = '0;
    logic [4:0] id_rd = '0, ex_rd;
    logic [31:0] SrcA, SrcB, ALUResult, ex_result, redirect_pc;
    logic [3:0] Operation, retired_cnt;
    logic ex_valid, ex_ready = 1'b0, ex_we, ex_illegal, redirect;
    int checks = 0, errors = 0;
    logic mv = 1'b0, m_f7 = 1'b0;
    logic [6:0] m_op = '0;
    logic [2:0] m_f3 = '0;
    logic [31:0] m_a = '0, m_b = '0, m_imm = '0, m_pc = '0;
    logic [4:0] m_rd = '0;
    logic [3:0] mcnt = '0, c0;

    alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
        .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
        .id_rd(id_rd), .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ALUResult(ALUResult),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result), .ex_rd(ex_rd),
        .ex_we(ex_we), .ex_illegal(ex_illegal), .redirect(redirect), .redirect_pc(redirect_pc),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu(input logic [31:0] a, b, input logic [3:0] c);
        case (c)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a - b;
            4'd4:  return a ^ b;
            4'd5:  return a >> b[4:0];
            4'd6:  return $signed(a) >>> b[4:0];
            4'd7:  return a << b[4:0];
            4'd8:  return {31'b0, $signed(a) < $signed(b)};
            4'd9:  return {31'b0, a == b};
            4'd10: return {31'b0, a != b};
            4'd11: return {31'b0, $signed(a) >= $signed(b)};
            default: return '0;
        endcase
    endfunction
    assign ALUResult = alu(SrcA, SrcB, Operation);

    function automatic logic legal(input logic [6:0] op, input logic [2:0] f3);
        if (op == OPC_OP || op == OPC_IMM) return f3 != 3'd3;
        if (op == OPC_BR) return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5;
        return 1'b0;
    endfunction

    function automatic logic [3:0] code(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        if (!legal(op, f3)) return 4'd0;
        if (op == OPC_BR) return f3 == 3'd0 ? 4'd9 : f3 == 3'd1 ? 4'd10 : f3 == 3'd4 ? 4'd8 : 4'd11;
        case (f3)
            3'd0:    return (op == OPC_OP && f7) ? 4'd3 : 4'd2;
            3'd1:    return 4'd7;
            3'd2:    return 4'd8;
            3'd4:    return 4'd4;
            3'd5:    return f7 ? 4'd6 : 4'd5;
            3'd6:    return 4'd1;
            default: return 4'd0;
        endcase
    endfunction

    // Instruction semantics: ALU value for OP/OP-IMM, taken bit for branches.
    function automatic logic [31:0] value(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                          input logic [31:0] a, rs2, imm);
        logic [31:0] b;
        b = op == OPC_IMM ? imm : rs2;
        if (op == OPC_BR)
            case (f3)
                3'd0:    return {31'b0, a == b};
                3'd1:    return {31'b0, a != b};
                3'd4:    return {31'b0, $signed(a) < $signed(b)};
                default: return {31'b0, $signed(a) >= $signed(b)};
            endcase
        case (f3)
            3'd0:    return (op == OPC_OP && f7) ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return $signed(a) < $signed(b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, iv, input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, b, im, p, input logic [4:0] rd, input logic er);
        logic lg, alu_c, br_c, fire, rdr, idr;
        logic [31:0] val;
        reset = r; id_valid = iv; id_opcode = opc; id_funct3 = f3; id_funct7b5 = f7;
        id_rs1_data = a; id_rs2_data = b; id_imm = im; id_pc = p; id_rd = rd; ex_ready = er;
        #1;
        lg    = legal(m_op, m_f3);
        alu_c = lg && m_op != OPC_BR;
        br_c  = lg && m_op == OPC_BR;
        val   = value(m_op, m_f3, m_f7, m_a, m_b, m_imm);
        fire  = mv && er;
        rdr   = fire && br_c && val[0];
        idr   = (!mv || er) && !rdr;
        check("ex_valid", ex_valid, mv);
        check("id_ready", id_ready, idr);
        check("redirect", redirect, rdr);
        check("ex_we", ex_we, mv && alu_c);
        check("retired_cnt", retired_cnt, mcnt);
        if (mv) begin
            check("Operation", Operation, code(m_op, m_f3, m_f7));
            check("SrcA", SrcA, lg ? m_a : 32'd0);
            check("SrcB", SrcB, lg ? (m_op == OPC_IMM ? m_imm : m_b) : 32'd0);
            check("ex_result", ex_result, alu_c ? val : 32'd0);
            check("ex_rd", ex_rd, m_rd);
            check("ex_illegal", ex_illegal, !lg);
            if (br_c) check("redirect_pc", redirect_pc, m_pc + m_imm);
        end
        if (r) begin
            mv = 1'b0; mcnt = '0;
        end else begin
            if (iv && idr) begin
                mv = 1'b1; m_op = opc; m_f3 = f3; m_f7 = f7; m_a = a; m_b = b;
                m_imm = im; m_pc = p; m_rd = rd;
            end else if (fire) mv = 1'b0;
            if (fire) mcnt = mcnt + 4'd1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic er);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0, '0, er);
    endtask

    initial begin
        logic [6:0] opc;
        int sel;
        repeat (2) @(negedge clk);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0, '0, 1'b0);
        check("rst_valid", ex_valid, 1'b0);
        check("rst_id_ready", id_ready, 1'b1);
        check("rst_op", Operation, 4'd0);
        check("rst_cnt", retired_cnt, 4'd0);
        step(1'b0, 1'b1, OPC_OP, 3'd0, 1'b1, 32'd10, 32'd3, '0, '0, 5'd5, 1'b0);
        check("sub_op", Operation, 4'b0011);
        check("sub_a", SrcA, 32'd10);
        check("sub_b", SrcB, 32'd3);
        check("sub_res", ex_result, 32'd7);
        check("sub_we", ex_we, 1'b1);
        idle(1'b1);
        check("sub_cnt", retired_cnt, 4'd1);
        step(1'b0, 1'b1, OPC_IMM, 3'd5, 1'b1, 32'h8000_0000, '0, 32'd4, '0, 5'd6, 1'b1);
        check("sra_op", Operation, 4'b0110);
        check("sra_res", ex_result, 32'hF800_0000);
        step(1'b0, 1'b1, OPC_BR, 3'd0, 1'b0, 32'd5, 32'd5, 32'h20, 32'h100, 5'd0, 1'b1);
        check("br_redirect", redirect, 1'b1);
        check("br_target", redirect_pc, 32'h120);
        check("br_id_ready", id_ready, 1'b0);
        check("br_we", ex_we, 1'b0);
        step(1'b0, 1'b1, OPC_OP, 3'd0, 1'b0, 32'd1, 32'd1, '0, '0, 5'd7, 1'b1);
        check("wrong_path", ex_valid, 1'b0);
        step(1'b0, 1'b1, OPC_OP, 3'd0, 1'b0, 32'd20, 32'd22, '0, '0, 5'd8, 1'b1);
        c0 = retired_cnt;
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, OPC_OP, 3'd4, 1'b0, 32'(i + 99), 32'd1, '0, '0, 5'd9, 1'b0);
        check("stall_a", SrcA, 32'd20);
        check("stall_op", Operation, 4'b0010);
        check("stall_id_ready", id_ready, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check("stall_cnt", retired_cnt, 4'(c0 + 4'd1));
        step(1'b0, 1'b1, 7'b0110111, 3'd0, 1'b0, 32'd3, 32'd4, 32'd5, '0, 5'd3, 1'b0);
        check("ill_flag", ex_illegal, 1'b1);
        check("ill_we", ex_we, 1'b0);
        check("ill_res", ex_result, 32'd0);
        idle(1'b1);
        step(1'b0, 1'b1, OPC_OP, 3'd7, 1'b0, 32'd6, 32'd3, '0, '0, 5'd1, 1'b0);
        idle(1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0, '0, 1'b0);
        check("rst_stall_valid", ex_valid, 1'b0);
        check("rst_stall_cnt", retired_cnt, 4'd0);
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b1, OPC_OP, 3'd6, 1'b0, 32'(i), 32'd1, '0, '0, 5'd2, 1'b1);
        idle(1'b1);
        check("cnt_wrap", retired_cnt, 4'd0);
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 9);
            opc = sel < 4 ? OPC_OP : sel < 7 ? OPC_IMM : sel < 9 ? OPC_BR : 7'($urandom);
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, opc, 3'($urandom),
                 1'($urandom), $urandom, $urandom, $urandom_range(0, 1) ? 32'($urandom_range(0, 40)) : $urandom,
                 $urandom, 5'($urandom), $urandom_range(0, 3) != 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
